dq_quad_sequencer: RTL and testbench



---
 rtl/dq_quad_sequencer_if.sv | 46 ++++
 rtl/dq_quad_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dq_quad_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dq_quad_sequencer_if.sv
// dq_quad_sequencer_if: decoder-side and data-memory-side signals of the DQ
// quadword sequencer. The sequencer connects through the slave modport. The
// decoder/memory side (or a testbench) connects through the master modport.
// All vectors are big-endian ([0] is the most significant bit).
interface dq_quad_sequencer_if #(
  parameter int regWidth  = 5,
  parameter int immWidth  = 12,
  parameter int addrWidth = 64,
  parameter int dataWidth = 64
);
  // Decoder side
  logic                     enable_i;
  logic [0:1]               op_i;
  logic [0:regWidth-1]      reg1_i;
  logic [0:regWidth-1]      reg2_i;
  logic [0:immWidth-1]      imm_i;
  logic                     bit_i;
  logic [0:addrWidth-1]     baseVal_i;
  logic [0:2*dataWidth-1]   storeData_i;
  logic                     stall_o;

  // Data-memory side
  logic                     memValid_o;
  logic                     memReady_i;
  logic                     memWrite_o;
  logic [0:addrWidth-1]     memAddr_o;
  logic [0:dataWidth-1]     memData_o;
  logic                     memBeat_o;
  logic [0:regWidth]        memTag_o;
  logic                     done_o;
  logic                     alignFault_o;

  modport slave (
    input  enable_i, op_i, reg1_i, reg2_i, imm_i, bit_i, baseVal_i, storeData_i,
    input  memReady_i,
    output stall_o, memValid_o, memWrite_o, memAddr_o, memData_o, memBeat_o,
    output memTag_o, done_o, alignFault_o
  );

  modport master (
    output enable_i, op_i, reg1_i, reg2_i, imm_i, bit_i, baseVal_i, storeData_i,
    output memReady_i,
    input  stall_o, memValid_o, memWrite_o, memAddr_o, memData_o, memBeat_o,
    input  memTag_o, done_o, alignFault_o
  );
endinterface

// File: rtl/dq_quad_sequencer.sv
// dq_quad_sequencer: accepts one decoded DQ-form quadword operation (lq, lxv,
// stxv), forms EA = (RA|0) + EXTS(DQ||0b0000) and issues it to the data-memory
// port as two 64-bit beats (EA, then EA+8) under a valid/ready handshake.
// stall_o back-pressures the decoder while an operation is in flight.
// Optional feature: define DQ_ALIGN_CHECK_EN to fault, rather than issue, any
// EA that is not 16-byte aligned. When it is not defined, alignFault_o stays 0.
module dq_quad_sequencer #(
  parameter int regWidth  = 5,
  parameter int immWidth  = 12,
  parameter int addrWidth = 64,
  parameter int dataWidth = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  dq_quad_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  localparam logic [1:0] OP_STXV = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  state_e               state_q, state_d;
  logic                 stall_q, stall_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_write_q, mem_write_d;
  logic                 mem_beat_q, mem_beat_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic [0:addrWidth-1] mem_addr_q, mem_addr_d;
  logic [0:dataWidth-1] mem_data_q, mem_data_d;
  logic [0:dataWidth-1] data1_q, data1_d;   // second store beat, waiting for BEAT1
  logic [0:regWidth]    tag_q, tag_d;

  logic [0:addrWidth-1] base;
  logic [0:addrWidth-1] disp;
  logic [0:addrWidth-1] ea;
  logic                 misaligned;

  // Next-state, EA formation and output computation for the beat sequencer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    stall_d     = stall_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_beat_d  = mem_beat_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    data1_d     = data1_q;
    tag_d       = tag_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;

    // RA = 0 means a literal zero base. The displacement is DQ||0b0000
    // sign-extended. The 64-bit add wraps silently.
    base = (bus.reg2_i == '0) ? '0 : bus.baseVal_i;
    disp = {{(addrWidth-immWidth-4){bus.imm_i[0]}}, bus.imm_i, 4'b0000};
    ea   = base + disp;

`ifdef DQ_ALIGN_CHECK_EN
    misaligned = (ea[addrWidth-4:addrWidth-1] != 4'b0000);
`else
    misaligned = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.enable_i && (bus.op_i != OP_RSVD)) begin
          tag_d = {bus.bit_i, bus.reg1_i};
          if (misaligned) begin
            // A faulting access issues no beats and leaves the sequencer idle.
            fault_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            stall_d     = 1'b1;
            mem_valid_d = 1'b1;
            mem_write_d = (bus.op_i == OP_STXV);
            mem_beat_d  = 1'b0;
            mem_addr_d  = ea;
            mem_data_d  = bus.storeData_i[0:dataWidth-1];
            data1_d     = bus.storeData_i[dataWidth:2*dataWidth-1];
          end
        end
      end
      BEAT0: begin
        if (bus.memReady_i) begin
          state_d    = BEAT1;
          mem_beat_d = 1'b1;
          mem_addr_d = mem_addr_q + addrWidth'(8);
          mem_data_d = data1_q;
        end
      end
      BEAT1: begin
        if (bus.memReady_i) begin
          // The tag stays on memTag_o so it qualifies the done pulse.
          state_d     = IDLE;
          stall_d     = 1'b0;
          mem_valid_d = 1'b0;
          mem_write_d = 1'b0;
          mem_beat_d  = 1'b0;
          mem_addr_d  = '0;
          mem_data_d  = '0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        stall_d     = 1'b0;
        mem_valid_d = 1'b0;
        mem_write_d = 1'b0;
        mem_beat_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs. Reset aborts any operation in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: the datapath registers are reset as well because they drive outputs that must read 0 out of reset.
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_beat_q  <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      data1_q     <= '0;
      tag_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value from the same edge.
      state_q     <= state_d;
      stall_q     <= stall_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_beat_q  <= mem_beat_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      data1_q     <= data1_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.stall_o      = stall_q;
  assign bus.memValid_o   = mem_valid_q;
  assign bus.memWrite_o   = mem_write_q;
  assign bus.memBeat_o    = mem_beat_q;
  assign bus.memAddr_o    = mem_addr_q;
  assign bus.memData_o    = mem_data_q;
  assign bus.memTag_o     = tag_q;
  assign bus.done_o       = done_q;
  assign bus.alignFault_o = fault_q;

endmodule

// File: tb/tb_dq_quad_sequencer.sv
// tb_dq_quad_sequencer: directed and randomized operations checked against a
// behavioural model of the quadword sequencer. The model computes the EA with
// plain signed arithmetic and the expected beat sequence for each operation.
module tb_dq_quad_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dq_quad_sequencer_if bus_if ();

  dq_quad_sequencer dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks handshake/status outputs every time. Checks beat fields only while
  // a beat is valid. Checks the tag whenever done or a fault qualifies it.
  task automatic check_out(input string tag, input bit valid, input bit stall,
                           input bit done, input bit fault, input bit write,
                           input bit [63:0] addr, input bit [63:0] data,
                           input bit beat, input bit [5:0] mtag);
    check({tag, ".valid"}, bus_if.memValid_o, valid);
    check({tag, ".stall"}, bus_if.stall_o, stall);
    check({tag, ".done"},  bus_if.done_o, done);
    check({tag, ".fault"}, bus_if.alignFault_o, fault);
    if (valid) begin
      check({tag, ".addr"},  bus_if.memAddr_o, addr);
      check({tag, ".data"},  bus_if.memData_o, data);
      check({tag, ".beat"},  bus_if.memBeat_o, beat);
      check({tag, ".write"}, bus_if.memWrite_o, write);
    end
    if (valid || done || fault) check({tag, ".tag"}, bus_if.memTag_o, mtag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".stall"}, bus_if.stall_o, 0);
    check({tag, ".valid"}, bus_if.memValid_o, 0);
    check({tag, ".write"}, bus_if.memWrite_o, 0);
    check({tag, ".addr"},  bus_if.memAddr_o, 0);
    check({tag, ".data"},  bus_if.memData_o, 0);
    check({tag, ".beat"},  bus_if.memBeat_o, 0);
    check({tag, ".tag"},   bus_if.memTag_o, 0);
    check({tag, ".done"},  bus_if.done_o, 0);
    check({tag, ".fault"}, bus_if.alignFault_o, 0);
  endtask

  task automatic drive(input bit en, input bit [1:0] op, input bit [4:0] r1,
                       input bit [4:0] r2, input bit [11:0] imm, input bit b,
                       input bit [63:0] base, input bit [127:0] sd);
    bus_if.enable_i    = en;
    bus_if.op_i        = op;
    bus_if.reg1_i      = r1;
    bus_if.reg2_i      = r2;
    bus_if.imm_i       = imm;
    bus_if.bit_i       = b;
    bus_if.baseVal_i   = base;
    bus_if.storeData_i = sd;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'd0, 5'd0, 5'd0, 12'd0, 1'b0, 64'd0, 128'd0);
  endtask

  // A fresh, valid-looking request that the busy sequencer must ignore.
  task automatic drive_junk();
    drive(1'b1, 2'($urandom_range(0, 2)), 5'($urandom), 5'($urandom_range(1, 31)),
          12'($urandom), 1'($urandom), {$urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom});
  endtask

  // Reference model: EA = (RA ? base : 0) + EXTS(DQ||0b0000), then two beats
  // at EA and EA+8 carrying the high and low store halves.
  function automatic bit [63:0] model_ea(input bit [4:0] r2, input bit [11:0] imm,
                                         input bit [63:0] base);
    longint disp;
    disp = longint'(shortint'({imm, 4'b0000}));
    return ((r2 == 5'd0) ? 64'd0 : base) + 64'(disp);
  endfunction

  // One operation: present it, then walk the beats with d0/d1 stall cycles.
  task automatic do_op(input string name, input bit [1:0] op, input bit [4:0] r1,
                       input bit [4:0] r2, input bit [11:0] imm, input bit b,
                       input bit [63:0] base, input bit [127:0] sd,
                       input int d0, input int d1);
    bit [63:0] ea;
    bit [63:0] exp_addr [2];
    bit [63:0] exp_data [2];
    bit [5:0]  t;
    bit        wr;
    bit        fault_exp;

    ea          = model_ea(r2, imm, base);
    exp_addr[0] = ea;
    exp_addr[1] = ea + 64'd8;
    exp_data[0] = sd[127:64];
    exp_data[1] = sd[63:0];
    t           = {b, r1};
    wr          = (op == 2'd2);
    fault_exp   = 1'b0;
`ifdef DQ_ALIGN_CHECK_EN
    fault_exp   = (ea[3:0] != 4'd0);
`endif

    drive(1'b1, op, r1, r2, imm, b, base, sd);
    bus_if.memReady_i = 1'($urandom);   // must be ignored while idle
    @(posedge clk); #1;

    if (op == 2'd3) begin
      check_out({name, ".rsvd"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_idle();
      bus_if.memReady_i = 1'b0;
      return;
    end

    if (fault_exp) begin
      check_out({name, ".fault"}, 0, 0, 0, 1, 0, 0, 0, 0, t);
      drive_idle();
      bus_if.memReady_i = 1'b0;
      @(posedge clk); #1;
      check_out({name, ".fault_end"}, 0, 0, 0, 0, 0, 0, 0, 0, t);
      return;
    end

    check_out({name, ".b0"}, 1, 1, 0, 0, wr, exp_addr[0], exp_data[0], 0, t);

    for (int bt = 0; bt < 2; bt++) begin
      int d;
      d = (bt == 0) ? d0 : d1;
      for (int i = 0; i < d; i++) begin
        drive_junk();
        bus_if.memReady_i = 1'b0;
        @(posedge clk); #1;
        check_out({name, ".hold"}, 1, 1, 0, 0, wr, exp_addr[bt], exp_data[bt], 1'(bt), t);
      end
      drive_junk();
      bus_if.memReady_i = 1'b1;
      @(posedge clk); #1;
      if (bt == 0)
        check_out({name, ".b1"}, 1, 1, 0, 0, wr, exp_addr[1], exp_data[1], 1, t);
      else
        check_out({name, ".done"}, 0, 0, 1, 0, 0, 0, 0, 0, t);
    end

    drive_idle();
    bus_if.memReady_i = 1'b0;
    @(posedge clk); #1;
    check_out({name, ".post"}, 0, 0, 0, 0, 0, 0, 0, 0, t);
  endtask

  initial begin
    bit [63:0] base;
    bit [4:0]  r2;

    rst = 1'b1;
    drive_idle();
    bus_if.memReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // lq: RA=3, base 0x1000, DQ=2 -> 0x1020 / 0x1028, memory always ready
    do_op("lq", 2'd0, 5'd7, 5'd3, 12'h002, 1'b0, 64'h1000,
          {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, 0, 0);

    // stxv: RA=0, DQ=0xFFF -> EA = -16, beat1 wraps to ...FFF8
    do_op("stxv", 2'd2, 5'd9, 5'd0, 12'hFFF, 1'b0, 64'hDEAD_BEEF_0000_0000,
          {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, 1, 0);

    // lxv: SX=1, RT=5 -> tag 0x25, beat0 stalled 4 cycles with junk enables
    do_op("lxv", 2'd1, 5'd5, 5'd4, 12'h010, 1'b1, 64'h0000_0000_8000_0000,
          {$urandom, $urandom, $urandom, $urandom}, 4, 1);

    // Reset while in BEAT1: outputs clear at once, no done follows
    drive(1'b1, 2'd0, 5'd1, 5'd2, 12'h001, 1'b0, 64'h2000, 128'h1);
    bus_if.memReady_i = 1'b0;
    @(posedge clk); #1;
    check_out("rst.b0", 1, 1, 0, 0, 0, 64'h2010, 64'h0, 0, 6'h01);
    drive_idle();
    bus_if.memReady_i = 1'b1;
    @(posedge clk); #1;
    check_out("rst.b1", 1, 1, 0, 0, 0, 64'h2018, 64'h1, 1, 6'h01);
    bus_if.memReady_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("rst.abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("rst.after");

    do_op("lq_after_rst", 2'd0, 5'd3, 5'd1, 12'h7FF, 1'b0, 64'h0000_1000_0000_0000,
          {$urandom, $urandom, $urandom, $urandom}, 0, 2);

    // Reserved op: no activity
    do_op("op3", 2'd3, 5'd1, 5'd1, 12'h001, 1'b0, 64'h3000, 128'h0, 0, 0);

    // Unaligned base: faults when the check is built in, issued otherwise
    do_op("unaligned", 2'd1, 5'd6, 5'd2, 12'h000, 1'b1, 64'h1004,
          {$urandom, $urandom, $urandom, $urandom}, 0, 1);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      base = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) base[3:0] = 4'd0;
      r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 5'($urandom), r2,
            12'($urandom), 1'($urandom), base,
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
